// File: rtl/sobel_mag_initiator.sv
// Sobel front end: loads a 3x3 window serially, computes Gx/Gy, drives the
// magnitude handshake with a stall timeout and hands the result downstream.
module sobel_mag_initiator #(
    parameter int unsigned START_HOLD = 2,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned TO_W       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [10:0] gx,
    output logic [10:0] gy,
    output logic        mag_start,
    input  logic        mag_valid,
    input  logic [7:0]  mag_in,
    output logic [7:0]  out_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timeout_err,
    output logic        busy
);
    localparam int unsigned HW = $clog2(START_HOLD + 1);

    typedef enum logic [2:0] {S_LOAD, S_CALC, S_ISSUE, S_ARM, S_WAIT, S_OUTPUT} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      win_q [9];
    logic [7:0]      win_d [9];
    logic [10:0]     gx_q, gx_d, gy_q, gy_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [7:0]      out_pix_q, out_pix_d;
    logic            terr_q, terr_d;
    logic            pix_ready_q, pix_ready_d;
    logic            mag_start_q, mag_start_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [10:0]     gx_pos, gx_neg, gy_pos, gy_neg;

    // Pixels zero-extended; 11-bit wraparound subtraction yields two's complement.
    always_comb begin
        gx_pos = {3'b0, win_q[2]} + {2'b0, win_q[5], 1'b0} + {3'b0, win_q[8]};
        gx_neg = {3'b0, win_q[0]} + {2'b0, win_q[3], 1'b0} + {3'b0, win_q[6]};
        gy_pos = {3'b0, win_q[6]} + {2'b0, win_q[7], 1'b0} + {3'b0, win_q[8]};
        gy_neg = {3'b0, win_q[0]} + {2'b0, win_q[1], 1'b0} + {3'b0, win_q[2]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        to_d      = to_q;
        hold_d    = hold_q;
        out_pix_d = out_pix_q;
        terr_d    = terr_q;
        case (state_q)
            S_LOAD: begin
                if (pix_valid && pix_ready_q) begin
                    for (int unsigned i = 0; i < 9; i++) begin
                        if (cnt_q == 4'(i)) win_d[i] = pix_in;
                    end
                    if (cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_CALC: begin
                gx_d    = gx_pos - gx_neg;
                gy_d    = gy_pos - gy_neg;
                hold_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (hold_q == HW'(START_HOLD - 1)) state_d = S_ARM;
                else hold_d = hold_q + 1'b1;
            end
            S_ARM: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mag_valid) begin
                    out_pix_d = mag_in;
                    state_d   = S_OUTPUT;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    out_pix_d = '0;
                    terr_d    = 1'b1;
                    state_d   = S_OUTPUT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
        // Handshake outputs are registered from the next state so they are glitch-free.
        pix_ready_d = (state_d == S_LOAD);
        mag_start_d = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUTPUT);
        busy_d      = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            to_q        <= '0;
            hold_q      <= '0;
            out_pix_q   <= '0;
            terr_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            mag_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            to_q        <= to_d;
            hold_q      <= hold_d;
            out_pix_q   <= out_pix_d;
            terr_q      <= terr_d;
            pix_ready_q <= pix_ready_d;
            mag_start_q <= mag_start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign pix_ready   = pix_ready_q;
    assign gx          = gx_q;
    assign gy          = gy_q;
    assign mag_start   = mag_start_q;
    assign out_pix     = out_pix_q;
    assign out_valid   = out_valid_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_sobel_mag_initiator.sv
// Directed bench for sobel_mag_initiator: hand-computed gradients, handshake
// timing, stale valid, timeout boundary, backpressure and mid-operation reset.
module tb_sobel_mag_initiator;
    typedef logic [7:0] win_t [9];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [10:0] gx, gy;
    logic        mag_start;
    logic        mag_valid = 1'b0;
    logic [7:0]  mag_in = '0;
    logic [7:0]  out_pix;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        timeout_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sobel_mag_initiator #(.START_HOLD(2), .TIMEOUT(64), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .gx(gx), .gy(gy), .mag_start(mag_start),
        .mag_valid(mag_valid), .mag_in(mag_in), .out_pix(out_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .timeout_err(timeout_err), .busy(busy)
    );

    task automatic send_window(input win_t w, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n;
            pix_in = w[i];
            pix_valid = 1'b1;
            n = 0;
            while (!pix_ready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin
                vectors++; miscompares++;
                $display("FAIL pix_accept[%0d]: pix_ready=%b required 1", i, pix_ready);
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    // Magnitude-unit model: drops a stale valid at k==stale_hold, answers with m at k==resp_at.
    task automatic run_txn(input win_t w, input logic [7:0] m, input int stale_hold,
                           input int resp_at, output int s_lat, output int start_hi,
                           output int lat, output logic [10:0] gx0, output logic [10:0] gy0,
                           output bit stable);
        send_window(w, 9);
        s_lat = 0;
        while (!mag_start && s_lat < 5) begin @(negedge clk); s_lat++; end
        gx0 = gx; gy0 = gy; stable = 1'b1; start_hi = 0; lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (mag_start) start_hi++;
            if (gx !== gx0 || gy !== gy0) stable = 1'b0;
            if (out_valid) begin lat = k; break; end
            if (k == stale_hold) mag_valid = 1'b0;
            if (k == resp_at) begin mag_valid = 1'b1; mag_in = m; end
            @(negedge clk);
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({pix_ready, busy, mag_start, out_valid, timeout_err, out_pix, gx, gy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got pr=%b busy=%b ms=%b ov=%b te=%b op=%h gx=%h gy=%h required all 0",
                     pix_ready, busy, mag_start, out_valid, timeout_err, out_pix, gx, gy);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_release_pr: got %b required 0", pix_ready); end
        @(negedge clk);
        vectors++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL first_clock_pr: pr=%b busy=%b required 1/0", pix_ready, busy);
        end
    endtask

    task automatic test_flat();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{default: 8'd100};
        run_txn(w, 8'd0, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (s_lat !== 1) begin miscompares++; $display("FAIL flat_start_lat: got %0d required 1", s_lat); end
        vectors++; if (shi !== 2) begin miscompares++; $display("FAIL flat_start_len: got %0d required 2", shi); end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL flat_out_lat: got %0d required 4", lat); end
        vectors++; if (g0 !== 11'h000 || h0 !== 11'h000) begin miscompares++; $display("FAIL flat_grad: gx=%h gy=%h required 000/000", g0, h0); end
        vectors++; if (out_pix !== 8'h00 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL flat_out: op=%h te=%b required 00/0", out_pix, timeout_err); end
        repeat (3) @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL flat_hold_valid: ov=%b busy=%b required 1/1", out_valid, busy); end
        accept_out();
        vectors++;
        if (out_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL flat_release: ov=%b pr=%b busy=%b required 0/1/0", out_valid, pix_ready, busy);
        end
    endtask

    task automatic test_vertical();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        run_txn(w, 8'd255, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h3FC || h0 !== 11'h000) begin miscompares++; $display("FAIL vert_grad: gx=%h gy=%h required 3fc/000", g0, h0); end
        vectors++; if (out_pix !== 8'd255) begin miscompares++; $display("FAIL vert_out: got %h required ff", out_pix); end
        accept_out();
        w = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
        run_txn(w, 8'd200, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h404 || h0 !== 11'h000) begin miscompares++; $display("FAIL mirror_grad: gx=%h gy=%h required 404/000", g0, h0); end
        vectors++; if (out_pix !== 8'd200) begin miscompares++; $display("FAIL mirror_out: got %h required c8", out_pix); end
        accept_out();
    endtask

    task automatic test_horizontal();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_txn(w, 8'd90, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h000 || h0 !== 11'h404) begin miscompares++; $display("FAIL horiz_grad: gx=%h gy=%h required 000/404", g0, h0); end
        repeat (2) @(negedge clk);
        vectors++;
        if (!st || gx !== 11'h000 || gy !== 11'h404) begin
            miscompares++; $display("FAIL horiz_stable: stable=%b gx=%h gy=%h required 1/000/404", st, gx, gy);
        end
        accept_out();
    endtask

    task automatic test_stale();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        mag_valid = 1'b1; mag_in = 8'hAA;
        run_txn(w, 8'h3C, 3, 5, s_lat, shi, lat, g0, h0, st);
        vectors++; if (lat !== 6) begin miscompares++; $display("FAIL stale_lat: got %0d required 6", lat); end
        vectors++; if (out_pix !== 8'h3C) begin miscompares++; $display("FAIL stale_out: got %h required 3c", out_pix); end
        vectors++; if (g0 !== 11'h050 || h0 !== 11'h0F0) begin miscompares++; $display("FAIL stale_grad: gx=%h gy=%h required 050/0f0", g0, h0); end
        accept_out();
    endtask

    task automatic test_timeout();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_txn(w, 8'h5A, 0, 66, s_lat, shi, lat, g0, h0, st);
        vectors++;
        if (lat !== 67 || out_pix !== 8'h5A || timeout_err !== 1'b0) begin
            miscompares++; $display("FAIL valid_at_limit: lat=%0d op=%h te=%b required 67/5a/0", lat, out_pix, timeout_err);
        end
        accept_out();
        run_txn(w, 8'h11, 0, -1, s_lat, shi, lat, g0, h0, st);
        vectors++; if (lat !== 67) begin miscompares++; $display("FAIL timeout_lat: got %0d required 67", lat); end
        vectors++;
        if (out_pix !== 8'h00 || out_valid !== 1'b1 || timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_out: op=%h ov=%b te=%b required 00/1/1", out_pix, out_valid, timeout_err);
        end
        vectors++; if (g0 !== 11'h7FB || h0 !== 11'h7FB) begin miscompares++; $display("FAIL timeout_grad: gx=%h gy=%h required 7fb/7fb", g0, h0); end
        accept_out();
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
        run_txn(w, 8'h42, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++;
        if (out_pix !== 8'h42 || timeout_err !== 1'b1 || lat !== 4) begin
            miscompares++; $display("FAIL sticky_err: op=%h te=%b lat=%0d required 42/1/4", out_pix, timeout_err, lat);
        end
        vectors++; if (g0 !== 11'h002 || h0 !== 11'h008) begin miscompares++; $display("FAIL sticky_grad: gx=%h gy=%h required 002/008", g0, h0); end
        accept_out();
    endtask

    task automatic test_backpressure();
        win_t w; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        run_txn(w, 8'hC3, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h008 || h0 !== 11'h018) begin miscompares++; $display("FAIL bp_grad: gx=%h gy=%h required 008/018", g0, h0); end
        pix_valid = 1'b1; pix_in = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (pix_ready !== 1'b0 || out_valid !== 1'b1 || out_pix !== 8'hC3) begin
                miscompares++; $display("FAIL bp_hold[%0d]: pr=%b ov=%b op=%h required 0/1/c3", i, pix_ready, out_valid, out_pix);
            end
        end
        pix_valid = 1'b0;
        accept_out();
        w = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        run_txn(w, 8'h10, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h3FC || h0 !== 11'h000) begin miscompares++; $display("FAIL bp_no_extra: gx=%h gy=%h required 3fc/000", g0, h0); end
        accept_out();
    endtask

    task automatic test_reset_mid();
        win_t w, junk; int s_lat, shi, lat; logic [10:0] g0, h0; bit st;
        w = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
        junk = '{default: 8'd255};
        mag_valid = 1'b0;
        send_window(junk, 9);
        repeat (6) @(negedge clk);
        vectors++; if (busy !== 1'b1 || timeout_err !== 1'b1) begin miscompares++; $display("FAIL pre_reset: busy=%b te=%b required 1/1", busy, timeout_err); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pix_ready, busy, mag_start, out_valid, timeout_err, out_pix, gx, gy} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: pr=%b busy=%b ms=%b ov=%b te=%b op=%h gx=%h gy=%h required all 0",
                     pix_ready, busy, mag_start, out_valid, timeout_err, out_pix, gx, gy);
        end
        @(negedge clk); rst_n = 1'b1;
        send_window(junk, 4);
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
        run_txn(w, 8'h21, 0, 2, s_lat, shi, lat, g0, h0, st);
        vectors++; if (g0 !== 11'h3FC || h0 !== 11'h000) begin miscompares++; $display("FAIL fresh_grad: gx=%h gy=%h required 3fc/000", g0, h0); end
        vectors++; if (out_pix !== 8'h21 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL fresh_out: op=%h te=%b required 21/0", out_pix, timeout_err); end
        accept_out();
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical();
        test_horizontal();
        test_stale();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
